// File: rtl/uart_cmd_decoder.sv
// rtl/uart_cmd_decoder.sv - UART byte-frame command decoder driving a 16-bit bus and returning response bytes
module uart_cmd_decoder #(
  parameter int TIMEOUT = 2000
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [7:0]  i_dat,
  input  logic        i_received,
  output logic [15:0] o_addr,
  output logic [15:0] o_wdat,
  output logic        o_we,
  output logic        o_cyc,
  input  logic        i_ack,
  input  logic [15:0] i_rdat,
  output logic [7:0]  o_tx_dat,
  output logic        o_tx_start,
  input  logic        i_tx_busy,
  output logic        o_err,
  output logic        o_overrun,
  output logic        o_busy
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR_H,
    ADDR_L,
    DATA_H,
    DATA_L,
    BUS,
    SEND,
    SENDWAIT
  } state_t;

  localparam logic [7:0]  CMD_WRITE = 8'h57;
  localparam logic [7:0]  CMD_READ  = 8'h52;
  localparam logic [7:0]  WRITE_ACK = 8'h4B;
  // Abort fires on the idle cycle that would bring the counter to TIMEOUT.
  localparam logic [15:0] IDLE_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  logic [15:0] idle_cnt;
  logic [7:0]  tx_next;
  logic        tx_more;

  assign o_busy = (state != IDLE);

  // Frame parser, bus master and response sequencer in one registered FSM.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state      <= IDLE;
      idle_cnt   <= 16'd0;
      o_addr     <= 16'd0;
      o_wdat     <= 16'd0;
      o_we       <= 1'b0;
      o_cyc      <= 1'b0;
      o_tx_dat   <= 8'd0;
      o_tx_start <= 1'b0;
      o_err      <= 1'b0;
      o_overrun  <= 1'b0;
      tx_next    <= 8'd0;
      tx_more    <= 1'b0;
    end else begin
      o_err     <= 1'b0;
      o_overrun <= 1'b0;
      case (state)
        IDLE: begin
          if (i_received) begin
            if (i_dat == CMD_WRITE) begin
              o_we     <= 1'b1;
              idle_cnt <= 16'd0;
              state    <= ADDR_H;
            end else if (i_dat == CMD_READ) begin
              o_we     <= 1'b0;
              idle_cnt <= 16'd0;
              state    <= ADDR_H;
            end else begin
              o_err <= 1'b1;
            end
          end
        end
        ADDR_H, ADDR_L, DATA_H, DATA_L: begin
          // A byte in the expiry cycle wins over the timeout.
          if (i_received) begin
            idle_cnt <= 16'd0;
            case (state)
              ADDR_H: begin
                o_addr[15:8] <= i_dat;
                state        <= ADDR_L;
              end
              ADDR_L: begin
                o_addr[7:0] <= i_dat;
                if (o_we) begin
                  state <= DATA_H;
                end else begin
                  o_cyc <= 1'b1;
                  state <= BUS;
                end
              end
              DATA_H: begin
                o_wdat[15:8] <= i_dat;
                state        <= DATA_L;
              end
              default: begin
                o_wdat[7:0] <= i_dat;
                o_cyc       <= 1'b1;
                state       <= BUS;
              end
            endcase
          end else if (idle_cnt == IDLE_LAST) begin
            idle_cnt <= 16'd0;
            o_err    <= 1'b1;
            state    <= IDLE;
          end else begin
            idle_cnt <= idle_cnt + 16'd1;
          end
        end
        BUS: begin
          if (i_received) begin
            o_overrun <= 1'b1;
          end
          if (o_cyc && i_ack) begin
            o_cyc    <= 1'b0;
            o_tx_dat <= o_we ? WRITE_ACK : i_rdat[15:8];
            tx_next  <= i_rdat[7:0];
            tx_more  <= !o_we;
            state    <= SEND;
          end
        end
        SEND: begin
          if (i_received) begin
            o_overrun <= 1'b1;
          end
          if (!i_tx_busy) begin
            o_tx_start <= 1'b1;
            state      <= SENDWAIT;
          end
        end
        SENDWAIT: begin
          if (i_received) begin
            o_overrun <= 1'b1;
          end
          // The start-pulse cycle is skipped because busy only rises after it.
          if (o_tx_start) begin
            o_tx_start <= 1'b0;
          end else if (!i_tx_busy) begin
            if (tx_more) begin
              o_tx_dat <= tx_next;
              tx_more  <= 1'b0;
              state    <= SEND;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// tb/tb_uart_cmd_decoder.sv - directed and randomized frame checks against a transaction-level model
module tb_uart_cmd_decoder;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic [7:0]  i_dat;
  logic        i_received;
  logic [15:0] o_addr;
  logic [15:0] o_wdat;
  logic        o_we;
  logic        o_cyc;
  logic        i_ack;
  logic [15:0] i_rdat;
  logic [7:0]  o_tx_dat;
  logic        o_tx_start;
  logic        i_tx_busy;
  logic        o_err;
  logic        o_overrun;
  logic        o_busy;

  int total = 0;
  int bad = 0;

  uart_cmd_decoder #(.TIMEOUT(10)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_dat(i_dat), .i_received(i_received),
    .o_addr(o_addr), .o_wdat(o_wdat), .o_we(o_we), .o_cyc(o_cyc), .i_ack(i_ack),
    .i_rdat(i_rdat), .o_tx_dat(o_tx_dat), .o_tx_start(o_tx_start), .i_tx_busy(i_tx_busy),
    .o_err(o_err), .o_overrun(o_overrun), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({o_cyc, o_tx_start, o_err, o_overrun, o_busy, o_we, o_addr, o_wdat, o_tx_dat});
  endfunction

  task automatic send_byte(input logic [7:0] b);
    i_dat = b;
    i_received = 1'b1;
    tick();
    i_received = 1'b0;
    i_dat = 8'($urandom);
  endtask

  task automatic send_frame(input logic we, input logic [15:0] addr, input logic [15:0] wdat,
                            input int max_gap);
    logic [7:0] q[$];
    q = {we ? 8'h57 : 8'h52, addr[15:8], addr[7:0]};
    if (we) q = {q, wdat[15:8], wdat[7:0]};
    for (int k = 0; k < q.size(); k++) begin
      send_byte(q[k]);
      if (k != q.size() - 1) begin
        int g;
        g = $urandom_range(0, max_gap);
        for (int j = 0; j < g; j++) tick();
      end
    end
  endtask

  // Bus responder and transmitter model; expected response bytes come from the command type.
  task automatic run_bus(input logic we, input logic [15:0] addr, input logic [15:0] wdat,
                         input logic [15:0] rd, input int ack_delay, input bit inject_ovr);
    logic [7:0] exp_q[$];
    int n;
    n = 0;
    while (!o_cyc && n < 20) begin tick(); n++; end
    check("cyc_up", 64'(o_cyc), 64'd1);
    check("bus_we_addr", 64'({o_we, o_addr}), 64'({we, addr}));
    if (we) check("bus_wdat", 64'(o_wdat), 64'(wdat));
    for (int k = 0; k < ack_delay; k++) begin
      tick();
      check("bus_hold", 64'({o_cyc, o_we, o_addr}), 64'({1'b1, we, addr}));
    end
    if (inject_ovr) begin
      send_byte(8'h57);
      check("overrun_pulse", 64'({o_overrun, o_cyc, o_addr}), 64'({2'b11, addr}));
      tick();
      check("overrun_clear", 64'({o_overrun, o_cyc, o_we}), 64'({2'b01, we}));
    end
    i_ack = 1'b1;
    i_rdat = rd;
    tick();
    i_ack = 1'b0;
    i_rdat = 16'($urandom);
    check("cyc_drop", 64'(o_cyc), 64'd0);
    if (we) exp_q = {8'h4B};
    else exp_q = {rd[15:8], rd[7:0]};
    foreach (exp_q[k]) begin
      int h;
      n = 0;
      while (!o_tx_start && n < 20) begin tick(); n++; end
      check("tx_start", 64'(o_tx_start), 64'd1);
      check("tx_dat", 64'(o_tx_dat), 64'(exp_q[k]));
      tick();
      i_tx_busy = 1'b1;
      check("tx_pulse_once", 64'(o_tx_start), 64'd0);
      h = $urandom_range(1, 4);
      for (int j = 0; j < h; j++) begin
        tick();
        check("tx_hold", 64'({o_tx_start, o_tx_dat}), 64'({1'b0, exp_q[k]}));
      end
      i_tx_busy = 1'b0;
      tick();
      check("tx_no_early", 64'(o_tx_start), 64'd0);
    end
    check("idle_after_frame", 64'(o_busy), 64'd0);
  endtask

  initial begin
    logic        we;
    logic [15:0] addr, wdat, rd;
    i_reset_n = 1'b0;
    i_dat = 8'd0;
    i_received = 1'b0;
    i_ack = 1'b0;
    i_rdat = 16'd0;
    i_tx_busy = 1'b0;
    tick();
    tick();
    check("reset_outs", all_outs(), 64'd0);
    i_reset_n = 1'b1;
    tick();
    check("post_reset_outs", all_outs(), 64'd0);

    send_frame(1'b1, 16'h1234, 16'hABCD, 0);
    run_bus(1'b1, 16'h1234, 16'hABCD, 16'h0000, 3, 1'b0);

    send_frame(1'b0, 16'h0010, 16'h0000, 0);
    run_bus(1'b0, 16'h0010, 16'h0000, 16'hBEEF, 2, 1'b0);

    send_byte(8'h41);
    check("bad_cmd_err", 64'({o_err, o_busy}), 64'({1'b1, 1'b0}));
    tick();
    check("bad_cmd_err_clear", 64'({o_err, o_busy}), 64'd0);
    send_frame(1'b1, 16'h5AA5, 16'h0F0F, 2);
    run_bus(1'b1, 16'h5AA5, 16'h0F0F, 16'h0000, 1, 1'b0);

    send_frame(1'b0, 16'hC001, 16'h0000, 1);
    run_bus(1'b0, 16'hC001, 16'h0000, 16'h1357, 2, 1'b1);

    send_byte(8'h57);
    send_byte(8'h12);
    for (int k = 1; k < 10; k++) begin
      tick();
      check("timeout_wait", 64'({o_err, o_busy}), 64'({1'b0, 1'b1}));
    end
    tick();
    check("timeout_err", 64'({o_err, o_busy}), 64'({1'b1, 1'b0}));
    tick();
    check("timeout_err_clear", 64'(o_err), 64'd0);

    send_byte(8'h57);
    send_byte(8'h12);
    for (int k = 1; k < 10; k++) tick();
    send_byte(8'h34);
    check("expiry_byte_taken", 64'({o_err, o_busy}), 64'({1'b0, 1'b1}));
    send_byte(8'hAB);
    send_byte(8'hCD);
    run_bus(1'b1, 16'h1234, 16'hABCD, 16'h0000, 0, 1'b0);

    for (int f = 0; f < 12; f++) begin
      int trail;
      we = 1'($urandom);
      addr = 16'($urandom);
      wdat = 16'($urandom);
      rd = 16'($urandom);
      send_frame(we, addr, wdat, 3);
      run_bus(we, addr, wdat, rd, $urandom_range(0, 4), 1'b0);
      trail = $urandom_range(0, 2);
      for (int k = 0; k < trail; k++) begin
        tick();
        check("idle_quiet", 64'({o_tx_start, o_cyc, o_busy}), 64'd0);
      end
    end

    send_frame(1'b0, 16'h00FF, 16'h0000, 0);
    tick();
    check("pre_reset_cyc", 64'(o_cyc), 64'd1);
    i_reset_n = 1'b0;
    tick();
    check("reset_mid_bus", all_outs(), 64'd0);
    i_reset_n = 1'b1;
    tick();
    check("reset_mid_bus_hold", all_outs(), 64'd0);

    send_frame(1'b1, 16'h0BAD, 16'hF00D, 0);
    tick();
    i_ack = 1'b1;
    tick();
    i_ack = 1'b0;
    tick();
    check("pre_reset_tx", 64'({o_tx_start, o_tx_dat}), 64'({1'b1, 8'h4B}));
    i_reset_n = 1'b0;
    tick();
    check("reset_mid_tx", all_outs(), 64'd0);
    i_reset_n = 1'b1;
    tick();
    send_frame(1'b0, 16'h2468, 16'h0000, 1);
    run_bus(1'b0, 16'h2468, 16'h0000, 16'hA55A, 1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
